truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 The block SHALL have parameter EXPECTED, default 8'hE0, holding the golden truth table, where bit i is the expected s for row i.
REQ-003 The block SHALL have parameter SETTLE, default 1, giving the cycles each row is driven before s is captured; a value of 0 SHALL be treated as 1.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  rising-edge clock.
- rst_n  input  1  async active-low reset.
- start  input  1  sweep request, sampled on clk.
- abort  input  1  cancel the sweep, sampled on clk.
- s  input  1  output of the 3-input function under control.
- a  output  1  function input, equal to row[2].
- b  output  1  function input, equal to row[1].
- c  output  1  function input, equal to row[0].
- busy  output  1  high while a sweep is running.
- done  output  1  high from sweep completion until the next accepted start.
- tt  output  8  captured truth table, where bit i is s for row i.
- pass  output  1  (tt == EXPECTED), valid while done=1.
- err_count  output  4  number of bits where tt differs from EXPECTED, range 0..8.
- first_err  output  3  lowest mismatching row index.
- err_valid  output  1  high when err_count != 0.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, DRIVE and DONE.
REQ-006 In IDLE or DONE, start=1 at a clk edge SHALL move the FSM to DRIVE and apply the following in that same edge:
- row = 0;
- settle counter = 0;
- tt, pass, err_count, first_err, err_valid and done all cleared.
REQ-007 In DRIVE, busy SHALL be 1 and {a,b,c} SHALL equal row; in IDLE and DONE, {a,b,c} SHALL be 3'b000.
REQ-008 In DRIVE, the settle counter SHALL increment every cycle.
REQ-009 On the edge where the settle counter equals SETTLE-1, the block SHALL do all of the following in that same edge:
- write s into tt[row];
- reset the settle counter;
- increment row.
REQ-010 When row 7 is captured, the FSM SHALL go to DONE, and done, pass, err_count, first_err and err_valid SHALL all become valid on that same edge.
REQ-011 Latency: with the start edge at edge 0, the capture of row i SHALL occur at edge (i+1)*SETTLE, and done SHALL rise after edge 8*SETTLE.
REQ-012 err_count SHALL be the popcount of (tt_final ^ EXPECTED), computed on the final table including row 7.
REQ-013 first_err SHALL be the lowest set bit index of the XOR; when there is no mismatch, first_err SHALL be 0 and err_valid SHALL be 0.
REQ-014 start while busy=1 SHALL be ignored, with no restart and no effect on row or tt.
REQ-015 abort=1 in DRIVE SHALL move the FSM to IDLE on the next edge, with the following results:
- busy=0, done=0;
- {a,b,c}=000;
- tt keeps the rows captured so far;
- pass, err_count, first_err and err_valid stay 0.
REQ-016 abort in IDLE or DONE SHALL have no effect.
REQ-017 abort and start asserted in the same cycle SHALL resolve with abort taking priority.
REQ-018 DONE SHALL be held indefinitely with all results stable until start, abort-free, is accepted.
REQ-019 Row wrap-around SHALL NOT occur: row 7 always terminates the sweep.
REQ-020 busy and done SHALL never be 1 simultaneously.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for clk, force all of the following:
- state=IDLE, row=0, settle counter=0;
- a=b=c=0, busy=0, done=0, tt=8'h00;
- pass=0, err_count=0, first_err=0, err_valid=0.
REQ-022 Assertion of rst_n during a sweep SHALL discard all partial results.
REQ-023 After rst_n deasserts, the first start SHALL be accepted on the next clk edge.

Verification
REQ-024 Scenario 1: s driven by (a&b)|(a&c), SETTLE=1, one-cycle start pulse -> {a,b,c} steps 000..111 on one row per cycle; done rises after edge 8; tt=8'hE0, pass=1, err_count=0, err_valid=0.
REQ-025 Scenario 2: s tied to 0, SETTLE=1 -> tt=8'h00, pass=0, err_count=3, first_err=5, err_valid=1.
REQ-026 Scenario 3: SETTLE=3, function as in scenario 1, start pulsed again at edge 5 -> the second start is ignored; done rises after edge 24; tt=8'hE0.
REQ-027 Scenario 4: abort asserted while row=3 -> next edge gives IDLE, busy=0, done=0, abc=000, tt[2:0]=3'b000, err_count=0.
REQ-028 Scenario 5: rst_n pulsed low mid-clock-period while row=5 -> all outputs reach their reset values before the next clk edge; a subsequent start produces a full correct sweep.
REQ-029 Scenario 6: start asserted in DONE after a failing sweep, with s switched to the correct function -> results clear on the start edge; the new sweep ends with pass=1 and err_valid=0.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Drives rows 0..7 onto {a,b,c}, captures s into a truth table after each row has
// settled, and compares the finished table against a golden EXPECTED table.
module truth_table_sweeper #(
    parameter logic [7:0] EXPECTED = 8'hE0,
    parameter int         SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       s,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_err,
    output logic       err_valid
);

    // A settle time of 0 is treated as 1 so every row is held at least one cycle.
    localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CW = ($clog2(SETTLE_EFF) < 1) ? 1 : $clog2(SETTLE_EFF);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    row;
    logic [CW-1:0] cnt;
    logic          accept, capture, finish;
    logic [7:0]    tt_final, diff;
    logic [3:0]    diff_cnt;
    logic [2:0]    diff_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Abort outranks both start and capture; start is only honoured when not busy.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    capture = 1'b1;
                    if (row == 3'd7) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Results are computed from the table including the row being captured now.
    always_comb begin
        tt_final      = tt;
        tt_final[row] = s;
        diff          = tt_final ^ EXPECTED;
        diff_cnt      = 4'd0;
        diff_first    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            diff_cnt = diff_cnt + {3'b000, diff[i]};
        end
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) diff_first = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row       <= 3'd0;
            cnt       <= '0;
            tt        <= 8'h00;
            pass      <= 1'b0;
            err_count <= 4'd0;
            first_err <= 3'd0;
            err_valid <= 1'b0;
        end else if (accept) begin
            row       <= 3'd0;
            cnt       <= '0;
            tt        <= 8'h00;
            pass      <= 1'b0;
            err_count <= 4'd0;
            first_err <= 3'd0;
            err_valid <= 1'b0;
        end else if (state == DRIVE && !abort) begin
            if (capture) begin
                tt  <= tt_final;
                cnt <= '0;
                row <= row + 3'd1;
                if (finish) begin
                    pass      <= (diff == 8'h00);
                    err_count <= diff_cnt;
                    first_err <= diff_first;
                    err_valid <= (diff_cnt != 4'd0);
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign busy      = (state == DRIVE);
    assign done      = (state == DONE);
    assign {a, b, c} = busy ? row : 3'b000;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) each driving a
// selectable 3-input function; expected tables are queued at start and checked at done.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_v [2];
    logic       abort_v [2];
    logic       s_v     [2];
    logic       a_v     [2];
    logic       b_v     [2];
    logic       c_v     [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       pass_v  [2];
    logic       ev_v    [2];
    logic [7:0] tt_v    [2];
    logic [3:0] ec_v    [2];
    logic [2:0] fe_v    [2];
    int         mode_v  [2];

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    // mode 0: (a&b)|(a&c), mode 1: constant 0, mode 2: constant 1
    function automatic logic fn(int mode, logic [2:0] r);
        case (mode)
            0:       return (r[2] & r[1]) | (r[2] & r[0]);
            1:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always_comb s_v[0] = fn(mode_v[0], {a_v[0], b_v[0], c_v[0]});
    always_comb s_v[1] = fn(mode_v[1], {a_v[1], b_v[1], c_v[1]});

    truth_table_sweeper #(.EXPECTED(8'hE0), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .s(s_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .tt(tt_v[0]), .pass(pass_v[0]), .err_count(ec_v[0]), .first_err(fe_v[0]),
        .err_valid(ev_v[0])
    );

    truth_table_sweeper #(.EXPECTED(8'hE0), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .s(s_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .tt(tt_v[1]), .pass(pass_v[1]), .err_count(ec_v[1]), .first_err(fe_v[1]),
        .err_valid(ev_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int d);
        check("rst_busy", busy_v[d], 1'b0);
        check("rst_done", done_v[d], 1'b0);
        check("rst_abc", {a_v[d], b_v[d], c_v[d]}, 3'b000);
        check("rst_tt", tt_v[d], 8'h00);
        check("rst_pass", pass_v[d], 1'b0);
        check("rst_err_count", ec_v[d], 4'd0);
        check("rst_first_err", fe_v[d], 3'd0);
        check("rst_err_valid", ev_v[d], 1'b0);
    endtask

    task automatic check_results(input int d);
        logic [7:0] exp_tt, x;
        logic [3:0] n;
        logic [2:0] fe;
        logic       found;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1'b1, 1'b0);
            return;
        end
        exp_tt = exp_q.pop_front();
        x      = exp_tt ^ 8'hE0;
        n      = 4'd0;
        fe     = 3'd0;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) begin
                n = n + 4'd1;
                if (!found) begin
                    fe    = 3'(i);
                    found = 1'b1;
                end
            end
        end
        check("res_tt", tt_v[d], exp_tt);
        check("res_pass", pass_v[d], (x == 8'h00));
        check("res_err_count", ec_v[d], n);
        check("res_first_err", fe_v[d], fe);
        check("res_err_valid", ev_v[d], (n != 4'd0));
    endtask

    // Full sweep on instance d; optionally re-pulses start at edge restart_at (relative to start edge 0).
    task automatic sweep(input int d, input int settle, input int mode, input int restart_at);
        logic [7:0] model;
        logic [2:0] rr;
        mode_v[d] = mode;
        for (int r = 0; r < 8; r++) model[r] = fn(mode, 3'(r));
        exp_q.push_back(model);
        start_v[d] = 1'b1;
        step();
        start_v[d] = 1'b0;
        check("clr_tt", tt_v[d], 8'h00);
        check("clr_pass", pass_v[d], 1'b0);
        check("clr_err_count", ec_v[d], 4'd0);
        check("clr_err_valid", ev_v[d], 1'b0);
        for (int e = 0; e < 8 * settle; e++) begin
            rr = 3'(e / settle);
            check("drive_abc", {a_v[d], b_v[d], c_v[d]}, rr);
            check("drive_busy", busy_v[d], 1'b1);
            check("drive_done", done_v[d], 1'b0);
            start_v[d] = (e == restart_at - 1);
            step();
        end
        start_v[d] = 1'b0;
        check("end_done", done_v[d], 1'b1);
        check("end_busy", busy_v[d], 1'b0);
        check("end_abc", {a_v[d], b_v[d], c_v[d]}, 3'b000);
        check_results(d);
    endtask

    // Starts a sweep, aborts while row 3 is driven, and checks the partial table.
    task automatic abort_at_row3(input int mode, input logic [7:0] exp_tt);
        mode_v[0]  = mode;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        step();
        step();
        step();
        check("abort_row", {a_v[0], b_v[0], c_v[0]}, 3'd3);
        abort_v[0] = 1'b1;
        step();
        abort_v[0] = 1'b0;
        check("abort_busy", busy_v[0], 1'b0);
        check("abort_done", done_v[0], 1'b0);
        check("abort_abc", {a_v[0], b_v[0], c_v[0]}, 3'b000);
        check("abort_tt", tt_v[0], exp_tt);
        check("abort_pass", pass_v[0], 1'b0);
        check("abort_err_count", ec_v[0], 4'd0);
        check("abort_err_valid", ev_v[0], 1'b0);
        step();
        check("abort_stays_idle", busy_v[0], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            mode_v[d]  = 0;
        end
        #3;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Correct function, SETTLE=1
        sweep(0, 1, 0, -1);

        // DONE holds through idle cycles, lone abort, and abort+start together
        step();
        step();
        abort_v[0] = 1'b1;
        step();
        abort_v[0] = 1'b0;
        check("hold_done", done_v[0], 1'b1);
        check("hold_tt", tt_v[0], 8'hE0);
        check("hold_pass", pass_v[0], 1'b1);
        abort_v[0] = 1'b1;
        start_v[0] = 1'b1;
        step();
        abort_v[0] = 1'b0;
        start_v[0] = 1'b0;
        check("abort_start_done", done_v[0], 1'b1);
        check("abort_start_busy", busy_v[0], 1'b0);
        check("abort_start_tt", tt_v[0], 8'hE0);

        // s tied low: failing sweep, then restart from DONE with the correct function
        sweep(0, 1, 1, -1);
        check("fail_first_err", fe_v[0], 3'd5);
        check("fail_err_count", ec_v[0], 4'd3);
        sweep(0, 1, 0, -1);

        // SETTLE=3 with an ignored second start at edge 5
        sweep(1, 3, 0, 5);

        // Abort during row 3 with two different functions
        abort_at_row3(0, 8'h00);
        abort_at_row3(2, 8'h07);
        abort_v[0] = 1'b1;
        step();
        abort_v[0] = 1'b0;
        check("idle_abort_busy", busy_v[0], 1'b0);
        check("idle_abort_tt", tt_v[0], 8'h07);

        // Asynchronous reset mid-period while row 5 is driven
        mode_v[0]  = 2;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_row", {a_v[0], b_v[0], c_v[0]}, 3'd5);
        check("pre_reset_tt", tt_v[0], 8'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        sweep(0, 1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
